// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory handshake and
// holds the IF/ID register, with a one-entry skid buffer for words returned during a stall.
module fetch_stage #(
  parameter int unsigned           WIDTH            = 8,
  parameter int unsigned           INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0]      RESETPC          = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        branchTaken,
  input  logic [WIDTH-1:0]            branchTarget,
  input  logic [INSTRUCTIONWIDTH-1:0] imemData,
  input  logic                        imemReady,
  output logic                        imemRequest,
  output logic [WIDTH-1:0]            imemAddress,
  output logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic [WIDTH-1:0]            pcDecode,
  output logic [WIDTH-1:0]            PCPlus8,
  output logic                        instructionValid
);

  typedef enum logic [1:0] {START, FETCH, HELD} state_t;

  localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);
  localparam logic [WIDTH-1:0] PC_AHEAD  = WIDTH'(8);

  state_t                        state_q;
  logic [WIDTH-1:0]              pc_q;
  logic [INSTRUCTIONWIDTH-1:0]   skid_instr_q;
  logic [WIDTH-1:0]              skid_pc_q;
  logic [INSTRUCTIONWIDTH-1:0]   instr_q;
  logic [WIDTH-1:0]              pc_decode_q;
  logic [WIDTH-1:0]              pc_plus8_q;
  logic                          valid_q;

  logic [WIDTH-1:0]              pc_step_d;
  logic [WIDTH-1:0]              pc_plus8_d;
  logic [WIDTH-1:0]              skid_plus8_d;

  // All PC arithmetic is WIDTH bits and wraps silently.
  assign pc_step_d    = pc_q + PC_STEP;
  assign pc_plus8_d   = pc_q + PC_AHEAD;
  assign skid_plus8_d = skid_pc_q + PC_AHEAD;

  // NOTE: every register here, skid buffer included, is cleared by the async reset and
  // updated only with non-blocking assignments, so all state advances together on an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= START;
      pc_q         <= RESETPC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      pc_decode_q  <= '0;
      pc_plus8_q   <= '0;
      valid_q      <= 1'b0;
    end else if (branchTaken) begin
      // Redirect wins over stall: flush IF/ID and the skid, drop any returning word.
      state_q      <= FETCH;
      pc_q         <= branchTarget;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      pc_decode_q  <= '0;
      pc_plus8_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        START: state_q <= FETCH;
        FETCH: begin
          if (!stall) begin
            if (imemReady) begin
              instr_q     <= imemData;
              pc_decode_q <= pc_q;
              pc_plus8_q  <= pc_plus8_d;
              valid_q     <= 1'b1;
              pc_q        <= pc_step_d;
            end else begin
              instr_q     <= '0;
              pc_decode_q <= '0;
              pc_plus8_q  <= '0;
              valid_q     <= 1'b0;
            end
          end else if (imemReady) begin
            // Decode is full: park the word so it is neither lost nor refetched.
            skid_instr_q <= imemData;
            skid_pc_q    <= pc_q;
            pc_q         <= pc_step_d;
            state_q      <= HELD;
          end
        end
        HELD: begin
          if (!stall) begin
            instr_q     <= skid_instr_q;
            pc_decode_q <= skid_pc_q;
            pc_plus8_q  <= skid_plus8_d;
            valid_q     <= 1'b1;
            state_q     <= FETCH;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

  assign imemRequest      = (state_q == FETCH);
  assign imemAddress      = pc_q;
  assign instruction      = instr_q;
  assign pcDecode         = pc_decode_q;
  assign PCPlus8          = pc_plus8_q;
  assign instructionValid = valid_q;

endmodule
